// File: rtl/pixel_plot_queue.sv
// Buffers drawer pixels in a small FIFO, clips off-screen coordinates and drains
// one pixel per cycle into the VGA plot port while tracking glyph/frame boundaries.
module pixel_plot_queue #(
    parameter int DEPTH    = 8,
    parameter int X_MAX    = 160,
    parameter int Y_MAX    = 120,
    parameter int COLOUR_W = 3
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [7:0]          in_x,
    input  logic [6:0]          in_y,
    input  logic [COLOUR_W-1:0] in_colour,
    input  logic                in_last,
    input  logic                stall,
    output logic [7:0]          vga_x,
    output logic [6:0]          vga_y,
    output logic [COLOUR_W-1:0] vga_colour,
    output logic                vga_plot,
    output logic                done,
    output logic                busy,
    output logic [7:0]          clip_count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = DEPTH[AW:0];

    typedef struct packed {
        logic [7:0]          x;
        logic [6:0]          y;
        logic [COLOUR_W-1:0] colour;
        logic                last;
        logic                drop;
    } PixelEntry;

    typedef enum logic {IDLE, RUN} FrameState;

    PixelEntry     mem [DEPTH];
    logic [AW-1:0] wrPtr;
    logic [AW-1:0] rdPtr;
    logic [AW:0]   count;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;
    logic          inDrop;
    PixelEntry     inEntry;
    PixelEntry     headEntry;
    FrameState     state;
    FrameState     stateNext;
    logic [7:0]    clipNext;

    assign full      = (count == FULL_COUNT);
    assign empty     = (count == '0);
    assign in_ready  = !full;
    assign push      = in_valid && !full;
    assign pop       = !empty && !stall;
    assign inDrop    = (int'(in_x) >= X_MAX) || (int'(in_y) >= Y_MAX);
    assign inEntry   = '{x: in_x, y: in_y, colour: in_colour, last: in_last, drop: inDrop};
    assign headEntry = mem[rdPtr];
    assign busy      = (state == RUN) || !empty;

    // Clipped pixels are stored too so that a clipped last pixel still ends the frame.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wrPtr] <= inEntry;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (push) begin
                wrPtr <= wrPtr + 1'b1;
            end
            if (pop) begin
                rdPtr <= rdPtr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            vga_x      <= '0;
            vga_y      <= '0;
            vga_colour <= '0;
            vga_plot   <= 1'b0;
            done       <= 1'b0;
        end else if (pop) begin
            vga_x      <= headEntry.x;
            vga_y      <= headEntry.y;
            vga_colour <= headEntry.colour;
            vga_plot   <= !headEntry.drop;
            done       <= headEntry.last;
        end else begin
            vga_plot   <= 1'b0;
            done       <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state      <= IDLE;
            clip_count <= '0;
        end else begin
            state      <= stateNext;
            clip_count <= clipNext;
        end
    end

    // A push coinciding with the last-pop begins the next frame, so the count restarts.
    always_comb begin
        stateNext = state;
        clipNext  = clip_count;
        case (state)
            IDLE: begin
                if (push) begin
                    stateNext = RUN;
                    clipNext  = {7'd0, inDrop};
                end
            end
            RUN: begin
                if (pop && headEntry.last) begin
                    if (push) begin
                        stateNext = RUN;
                        clipNext  = {7'd0, inDrop};
                    end else begin
                        stateNext = IDLE;
                    end
                end else if (push && inDrop && (clip_count != 8'hFF)) begin
                    clipNext = clip_count + 8'd1;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

endmodule

// File: tb/tb_pixel_plot_queue.sv
// Randomised and directed bench for pixel_plot_queue, checked every cycle against
// a queue-based model of the frame/clip rules plus a few literal expectations.
module tb_pixel_plot_queue;

    localparam int DEPTH    = 8;
    localparam int X_MAX    = 160;
    localparam int Y_MAX    = 120;
    localparam int COLOUR_W = 3;

    logic                clk;
    logic                resetn;
    logic                in_valid;
    logic                in_ready;
    logic [7:0]          in_x;
    logic [6:0]          in_y;
    logic [COLOUR_W-1:0] in_colour;
    logic                in_last;
    logic                stall;
    logic [7:0]          vga_x;
    logic [6:0]          vga_y;
    logic [COLOUR_W-1:0] vga_colour;
    logic                vga_plot;
    logic                done;
    logic                busy;
    logic [7:0]          clip_count;

    pixel_plot_queue #(.DEPTH(DEPTH), .X_MAX(X_MAX), .Y_MAX(Y_MAX), .COLOUR_W(COLOUR_W)) dut (
        .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready),
        .in_x(in_x), .in_y(in_y), .in_colour(in_colour), .in_last(in_last),
        .stall(stall), .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour),
        .vga_plot(vga_plot), .done(done), .busy(busy), .clip_count(clip_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int x;
        int y;
        int c;
        bit last;
        bit drop;
    } Pixel;

    Pixel queueModel[$];
    int   expX, expY, expC, expClip;
    bit   expPlot, expDone, inFrame, modelLive;
    int   checks = 0;
    int   failures = 0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [7:0] x, input logic [6:0] y,
                                 input logic [COLOUR_W-1:0] c, input logic l, input logic s);
        in_valid  = v;
        in_x      = x;
        in_y      = y;
        in_colour = c;
        in_last   = l;
        stall     = s;
        @(posedge clk);
        #1;
    endtask

    // Reference model: a plain queue of pixels plus the frame/clip bookkeeping rules.
    always @(posedge clk) begin
        Pixel p;
        Pixel head;
        bit   doPush, doPop, lastPopped;
        if (!resetn) begin
            queueModel.delete();
            expX = 0; expY = 0; expC = 0; expClip = 0;
            expPlot = 0; expDone = 0; inFrame = 0;
            modelLive = 1;
        end else if (modelLive) begin
            doPush     = in_valid && (queueModel.size() < DEPTH);
            doPop      = (queueModel.size() > 0) && !stall;
            lastPopped = 0;
            if (doPop) begin
                head = queueModel.pop_front();
                expX = head.x; expY = head.y; expC = head.c;
                expPlot = !head.drop;
                expDone = head.last;
                lastPopped = head.last;
            end else begin
                expPlot = 0;
                expDone = 0;
            end
            if (doPush) begin
                p.x = in_x; p.y = in_y; p.c = in_colour; p.last = in_last;
                p.drop = (in_x >= X_MAX) || (in_y >= Y_MAX);
                if (!inFrame || lastPopped) begin
                    inFrame = 1;
                    expClip = p.drop ? 1 : 0;
                end else if (p.drop && expClip < 255) begin
                    expClip++;
                end
                queueModel.push_back(p);
            end else if (lastPopped) begin
                inFrame = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (modelLive) begin
            checkOutput("in_ready", in_ready, queueModel.size() < DEPTH);
            checkOutput("vga_x", vga_x, expX);
            checkOutput("vga_y", vga_y, expY);
            checkOutput("vga_colour", vga_colour, expC);
            checkOutput("vga_plot", vga_plot, expPlot);
            checkOutput("done", done, expDone);
            checkOutput("busy", busy, inFrame || (queueModel.size() > 0));
            checkOutput("clip_count", clip_count, expClip);
        end
    end

    initial begin
        int  k;
        bit  accepted;
        logic [7:0] rx;
        logic [6:0] ry;
        modelLive = 0;
        resetn = 1'b0;
        applyStimulus(0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0);
        resetn = 1'b1;
        checkOutput("resetReady", in_ready, 1);
        checkOutput("resetBusy", busy, 0);
        checkOutput("resetPlot", vga_plot, 0);

        // Single legal pixel: plot two edges after it is offered.
        applyStimulus(1, 10, 20, 5, 1, 0);
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("singlePlot", vga_plot, 1);
        checkOutput("singleX", vga_x, 10);
        checkOutput("singleY", vga_y, 20);
        checkOutput("singleColour", vga_colour, 5);
        checkOutput("singleDone", done, 1);
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("singleBusyAfter", busy, 0);

        // Clipping frame with boundary coordinates.
        applyStimulus(1, 160, 0, 1, 0, 0);
        applyStimulus(1, 5, 120, 2, 0, 0);
        applyStimulus(1, 159, 119, 3, 1, 0);
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("boundaryPlot", vga_plot, 1);
        checkOutput("boundaryX", vga_x, 159);
        checkOutput("boundaryY", vga_y, 119);
        checkOutput("boundaryDone", done, 1);
        checkOutput("boundaryClips", clip_count, 2);

        // Clipped last pixel still completes the frame.
        applyStimulus(1, 200, 50, 4, 1, 0);
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("clippedLastPlot", vga_plot, 0);
        checkOutput("clippedLastDone", done, 1);
        checkOutput("clippedLastClips", clip_count, 1);
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("clippedLastBusy", busy, 0);

        // Stall fills the FIFO; ninth pixel is held off.
        k = 0;
        for (int i = 0; i < 10; i++) begin
            accepted = in_ready;
            applyStimulus(1, 8'(k), 0, 1, (k == 8), 1);
            if (accepted) k++;
        end
        checkOutput("stallAccepted", k, 8);
        checkOutput("stallFullReady", in_ready, 0);
        accepted = in_ready;
        applyStimulus(1, 8'(k), 0, 1, 1, 0);
        checkOutput("drainFirstX", vga_x, 0);
        checkOutput("drainReadyAfterPop", in_ready, 1);
        for (int i = 0; i < 20 && k < 9; i++) begin
            accepted = in_ready;
            applyStimulus(1, 8'(k), 0, 1, 1, 0);
            if (accepted) k++;
        end
        checkOutput("drainNinthAccepted", k, 9);
        for (int i = 0; i < 12; i++) applyStimulus(0, 0, 0, 0, 0, 0);

        // Stall toggling with continuous push from occupancy 3.
        for (int i = 0; i < 3; i++) applyStimulus(1, 8'(20 + i), 1, 2, 0, 1);
        for (int i = 0; i < 40; i++) applyStimulus(1, 8'(30 + i), 2, 3, (i == 39), (i % 2) == 0);
        for (int i = 0; i < 20; i++) applyStimulus(0, 0, 0, 0, 0, 0);

        // Mid-operation reset with buffered entries.
        for (int i = 0; i < 5; i++) applyStimulus(1, (i < 3) ? 8'd200 : 8'(i), 3, 1, 0, 1);
        checkOutput("preResetClips", clip_count, 3);
        resetn = 1'b0;
        applyStimulus(0, 0, 0, 0, 0, 1);
        resetn = 1'b1;
        checkOutput("postResetClips", clip_count, 0);
        checkOutput("postResetReady", in_ready, 1);
        checkOutput("postResetBusy", busy, 0);
        checkOutput("postResetX", vga_x, 0);
        for (int i = 0; i < 6; i++) applyStimulus(0, 0, 0, 0, 0, 0);

        // Randomised traffic with boundary-heavy coordinates and rare resets.
        for (int i = 0; i < 3000; i++) begin
            rx = ($urandom_range(0, 2) == 0) ? 8'(158 + $urandom_range(0, 3)) : 8'($urandom_range(0, 255));
            ry = ($urandom_range(0, 2) == 0) ? 7'(118 + $urandom_range(0, 3)) : 7'($urandom_range(0, 127));
            resetn = ($urandom_range(0, 399) != 0);
            applyStimulus($urandom_range(0, 3) != 0, rx, ry, 3'($urandom), $urandom_range(0, 5) == 0,
                          $urandom_range(0, 9) < 3);
        end
        resetn = 1'b1;
        for (int i = 0; i < 20; i++) applyStimulus(0, 0, 0, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
